// File: rtl/nes_video_timing_pkg.sv
// Shared types and constants for the NES video timing path.
package nes_video_pkg;

  typedef enum logic [1:0] {
    REGION_NTSC     = 2'd0,
    REGION_PAL      = 2'd1,
    REGION_DENDY    = 2'd2,
    REGION_NTSC_ALT = 2'd3
  } region_t;

  typedef enum logic [1:0] {
    SYNCED  = 2'd0,
    MISSING = 2'd1,
    FREE    = 2'd2
  } sync_state_t;

  localparam logic [8:0] V_TOTAL_NTSC   = 9'd262;
  localparam logic [8:0] V_TOTAL_PAL    = 9'd312;
  localparam logic [8:0] PPU_PRERENDER  = 9'd511;
  localparam logic [9:0] VBL_FIRST_LINE = 10'd240;

  // PAL and Dendy share the 312-line frame; code 3 falls back to NTSC.
  function automatic logic [8:0] v_total(input region_t r);
    return (r == REGION_PAL || r == REGION_DENDY) ? V_TOTAL_PAL : V_TOTAL_NTSC;
  endfunction

endpackage

// File: rtl/nes_video_timing_if.sv
// PPU-side inputs and video-side timing outputs of the timing block.
interface nes_video_timing_if;
  import nes_video_pkg::*;

  region_t    region;
  logic       crop_en;
  logic [8:0] count_h;
  logic [8:0] count_v;

  logic       ce_pix;
  logic       ce_pix_n;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       is_padding;
  logic       hblank;
  logic       vblank;
  logic       hsync;
  logic       vsync;
  logic       free_run;

  modport master (
    output region, crop_en, count_h, count_v,
    input  ce_pix, ce_pix_n, hc, vc, is_padding, hblank, vblank, hsync, vsync, free_run
  );

  modport slave (
    input  region, crop_en, count_h, count_v,
    output ce_pix, ce_pix_n, hc, vc, is_padding, hblank, vblank, hsync, vsync, free_run
  );

endinterface

// File: rtl/nes_video_timing_ce_div.sv
// Pixel clock-enable divider: one ce_pix and one mid-pixel ce_pix_n per CE_DIV clocks.
module nes_pix_ce_div #(
  parameter int CE_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic ce_pix_o,
  output logic ce_pix_n_o
);
  localparam int CNT_W = $clog2(CE_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CE_DIV / 2);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ce_pix_q, ce_pix_n_q;

  // Next divider count, wrapping at CE_DIV-1.
  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // Strobes come from the next count so each is high in the cycle cnt holds that value.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      ce_pix_q   <= 1'b0;
      ce_pix_n_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      ce_pix_q   <= (cnt_d == '0);
      ce_pix_n_q <= (cnt_d == CNT_MID);
    end
  end

  assign ce_pix_o   = ce_pix_q;
  assign ce_pix_n_o = ce_pix_n_q;

endmodule

// File: rtl/nes_video_timing.sv
// NES video timing: PPU-locked H/V position with free-run fallback, blanks, syncs, crop.
//
//  state   | meaning
//  SYNCED  | PPU frame wraps arriving, miss count 0
//  MISSING | internal frame wrapped without a PPU wrap, counting misses
//  FREE    | FREE_FRAMES misses seen; hc/vc come from the internal counters
module nes_video_timing
  import nes_video_pkg::*;
#(
  parameter int CE_DIV      = 4,
  parameter int H_TOTAL     = 341,
  parameter int H_ACTIVE    = 256,
  parameter int HBL_START   = 268,
  parameter int HBL_END     = 328,
  parameter int HS_START    = 278,
  parameter int HS_LEN      = 25,
  parameter int VS_START    = 244,
  parameter int VS_LEN      = 3,
  parameter int FREE_FRAMES = 3,
  parameter int CROP_H      = 10,
  parameter int CROP_V      = 8
) (
  input logic               clk,
  input logic               reset,
  nes_video_timing_if.slave vid
);
  localparam int MISS_W = $clog2(FREE_FRAMES + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(FREE_FRAMES);
  localparam logic [8:0] H_LAST     = 9'(H_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] HBL_S      = 10'(HBL_START);
  localparam logic [9:0] HBL_E      = 10'(HBL_END);
  localparam logic [9:0] HBL_CROP_S = 10'(HBL_START - CROP_H);
  localparam logic [9:0] HBL_CROP_E = 10'(HBL_END + CROP_H - 1);
  localparam logic [9:0] HS_S       = 10'(HS_START);
  localparam logic [9:0] HS_E       = 10'(HS_START + HS_LEN - 1);
  localparam logic [9:0] VS_S       = 10'(VS_START);
  localparam logic [9:0] VS_E       = 10'(VS_START + VS_LEN - 1);
  localparam logic [9:0] VBL_CROP_T = 10'(CROP_V - 1);
  localparam logic [9:0] VBL_CROP_B = 10'(240 - CROP_V - 2);
  localparam logic [9:0] PRERENDER  = 10'(PPU_PRERENDER);

  logic              ce_pix, ce_pix_n;
  sync_state_t       state_q, state_d;
  logic [8:0]        h_q, h_d, v_q, v_d;
  logic [8:0]        old_v_q, old_v_d;
  logic [8:0]        vtot_q, vtot_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              ppu_wrap;
  logic [9:0]        hc, vc;
  logic              hblank_q, hblank_d, vblank_q, vblank_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;

  nes_pix_ce_div #(.CE_DIV(CE_DIV)) u_ce_div (
    .clk        (clk),
    .reset      (reset),
    .ce_pix_o   (ce_pix),
    .ce_pix_n_o (ce_pix_n)
  );

  assign ppu_wrap = (old_v_q == PPU_PRERENDER) && (vid.count_v == 9'd0);
  assign hc = (state_q == FREE) ? {1'b0, h_q} : {1'b0, vid.count_h};
  assign vc = (state_q == FREE) ? {1'b0, v_q} : {1'b0, vid.count_v};

  // Sync state and internal position registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SYNCED;
      h_q     <= '0;
      v_q     <= '0;
      old_v_q <= '0;
      miss_q  <= '0;
      vtot_q  <= v_total(vid.region);
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
      old_v_q <= old_v_d;
      miss_q  <= miss_d;
      vtot_q  <= vtot_d;
    end
  end

  // Advance on each mid-pixel strobe; a PPU wrap overrides everything, region latches at frame wraps.
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    old_v_d = old_v_q;
    miss_d  = miss_q;
    vtot_d  = vtot_q;
    if (ce_pix_n) begin
      old_v_d = vid.count_v;
      if (ppu_wrap) begin
        h_d     = '0;
        v_d     = '0;
        miss_d  = '0;
        vtot_d  = v_total(vid.region);
        state_d = SYNCED;
      end else if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == vtot_q - 9'd1) begin
          v_d    = '0;
          vtot_d = v_total(vid.region);
          if (miss_q != MISS_MAX) miss_d = miss_q + MISS_W'(1);
          if (miss_d == MISS_MAX) state_d = FREE;
          else if (state_q == SYNCED) state_d = MISSING;
        end else begin
          v_d = v_q + 9'd1;
        end
      end else begin
        h_d = h_q + 9'd1;
      end
    end
  end

  // Blank and sync decode of the effective position.
  always_comb begin
    hblank_d = 1'b0;
    vblank_d = 1'b0;
    if (vid.crop_en) begin
      hblank_d = (hc >= HBL_CROP_S) && (hc <= HBL_CROP_E);
      vblank_d = (vc > VBL_CROP_B) || (vc < VBL_CROP_T);
    end else begin
      hblank_d = (hc >= HBL_S) && (hc <= HBL_E);
      vblank_d = ((vc >= VBL_FIRST_LINE) || ((vc == VBL_FIRST_LINE - 10'd1) && (hc > HBL_E)))
              && ((vc < PRERENDER) || ((vc == PRERENDER) && (hc <= HBL_E)));
    end
    hsync_d = (hc >= HS_S) && (hc <= HS_E);
    vsync_d = (vc >= VS_S) && (vc <= VS_E);
  end

  // Timing outputs update once per pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      hblank_q <= 1'b0;
      vblank_q <= 1'b0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
    end else if (ce_pix) begin
      hblank_q <= hblank_d;
      vblank_q <= vblank_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
    end
  end

  assign vid.ce_pix     = ce_pix;
  assign vid.ce_pix_n   = ce_pix_n;
  assign vid.hc         = hc;
  assign vid.vc         = vc;
  assign vid.is_padding = (hc >= H_ACT);
  assign vid.hblank     = hblank_q;
  assign vid.vblank     = vblank_q;
  assign vid.hsync      = hsync_q;
  assign vid.vsync      = vsync_q;
  assign vid.free_run   = (state_q == FREE);

endmodule
